partition_sweep_ctrl: RTL and testbench



---
 rtl/partition_sweep_ctrl.sv | 155 +++++++++++++++
 tb/tb_partition_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/partition_sweep_ctrl.sv
// partition_sweep_ctrl: exhaustive input sweep of one combinational partition.
// Drives exact and approximate copies in lockstep and accumulates the
// mismatch count, Hamming-distance sum, worst Hamming distance and the
// first failing vector.
module partition_sweep_ctrl #(
   parameter int unsigned NI     = 7,
   parameter int unsigned NO     = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            abort,
   output logic [NI-1:0]                   pi,
   input  logic [NO-1:0]                   po_exact,
   input  logic [NO-1:0]                   po_approx,
   output logic                            busy,
   output logic                            done,
   output logic                            results_valid,
   output logic [NI:0]                     mismatch_cnt,
   output logic [NI+$clog2(NO+1)-1:0]      hd_sum,
   output logic [$clog2(NO+1)-1:0]         max_hd,
   output logic [NI-1:0]                   first_err_vec,
   output logic                            first_err_valid
);

   localparam int unsigned MW = $clog2(NO + 1);
   localparam int unsigned CW = NI + 1;
   localparam int unsigned HW = NI + MW;
   localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [NI-1:0] LAST_VEC = {NI{1'b1}};
   localparam logic [SW-1:0] LAST_CNT = SW'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [SW-1:0]   r_cnt;
   logic [NI-1:0]   r_pi;
   logic            r_busy;
   logic            r_done;
   logic            r_results_valid;
   logic [CW-1:0]   r_mismatch_cnt;
   logic [HW-1:0]   r_hd_sum;
   logic [MW-1:0]   r_max_hd;
   logic [NI-1:0]   r_first_err_vec;
   logic            r_first_err_valid;
   logic [NO-1:0]   w_diff;
   logic [MW-1:0]   w_hd;

   // Per-vector difference and its Hamming weight
   always_comb begin
      w_diff = po_exact ^ po_approx;
      w_hd   = '0;
      for (int i = 0; i < int'(NO); i++) begin
         w_hd = w_hd + MW'(w_diff[i]);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; abort beats the last-vector transition to DONE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_SETTLE;
         S_SETTLE: begin
            if (abort)                 w_next = S_IDLE;
            else if (r_cnt == LAST_CNT) w_next = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (abort)                 w_next = S_IDLE;
            else if (r_pi == LAST_VEC) w_next = S_DONE;
            else                       w_next = S_SETTLE;
         end
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Vector counter, settle timer, status flags and metric accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt             <= '0;
         r_pi              <= '0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_results_valid   <= 1'b0;
         r_mismatch_cnt    <= '0;
         r_hd_sum          <= '0;
         r_max_hd          <= '0;
         r_first_err_vec   <= '0;
         r_first_err_valid <= 1'b0;
      end else begin
         r_busy <= (w_next == S_SETTLE) || (w_next == S_SAMPLE);
         r_done <= (w_next == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt             <= '0;
                  r_pi              <= '0;
                  r_results_valid   <= 1'b0;
                  r_mismatch_cnt    <= '0;
                  r_hd_sum          <= '0;
                  r_max_hd          <= '0;
                  r_first_err_vec   <= '0;
                  r_first_err_valid <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (!abort) begin
                  if (r_cnt == LAST_CNT) r_cnt <= '0;
                  else                   r_cnt <= r_cnt + SW'(1);
               end
            end
            S_SAMPLE: begin
               if (!abort) begin
                  if (w_diff != '0) begin
                     r_mismatch_cnt <= r_mismatch_cnt + CW'(1);
                     r_hd_sum       <= r_hd_sum + HW'(w_hd);
                     if (w_hd > r_max_hd) r_max_hd <= w_hd;
                     if (!r_first_err_valid) begin
                        r_first_err_vec   <= r_pi;
                        r_first_err_valid <= 1'b1;
                     end
                  end
                  if (r_pi == LAST_VEC) r_results_valid <= 1'b1;
                  else                  r_pi <= r_pi + NI'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign pi              = r_pi;
   assign busy            = r_busy;
   assign done            = r_done;
   assign results_valid   = r_results_valid;
   assign mismatch_cnt    = r_mismatch_cnt;
   assign hd_sum          = r_hd_sum;
   assign max_hd          = r_max_hd;
   assign first_err_vec   = r_first_err_vec;
   assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Scoreboard bench for partition_sweep_ctrl (SETTLE=1 and SETTLE=3 instances).
module tb_partition_sweep_ctrl;

   localparam int unsigned NI = 7;
   localparam int unsigned NO = 4;
   localparam int unsigned MW = 3;
   localparam int unsigned HW = NI + MW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   // Instance 1 (SETTLE=1)
   logic          start, abort, busy, done, rv, fvld;
   logic [NI-1:0] pi, fv;
   logic [NO-1:0] pe, pa;
   logic [NI:0]   mc;
   logic [HW-1:0] hs;
   logic [MW-1:0] mh;
   int            mode = 0;

   // Instance 3 (SETTLE=3)
   logic          start3, abort3, busy3, done3, rv3, fvld3;
   logic [NI-1:0] pi3, fv3;
   logic [NO-1:0] pe3, pa3;
   logic [NI:0]   mc3;
   logic [HW-1:0] hs3;
   logic [MW-1:0] mh3;

   partition_sweep_ctrl #(.NI(NI), .NO(NO), .SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pi(pi),
      .po_exact(pe), .po_approx(pa), .busy(busy), .done(done),
      .results_valid(rv), .mismatch_cnt(mc), .hd_sum(hs), .max_hd(mh),
      .first_err_vec(fv), .first_err_valid(fvld));

   partition_sweep_ctrl #(.NI(NI), .NO(NO), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .pi(pi3),
      .po_exact(pe3), .po_approx(pa3), .busy(busy3), .done(done3),
      .results_valid(rv3), .mismatch_cnt(mc3), .hd_sum(hs3), .max_hd(mh3),
      .first_err_vec(fv3), .first_err_valid(fvld3));

   // Partition pair models
   always_comb begin
      pe = pi[3:0] ^ {1'b0, pi[6:4]};
      case (mode)
         1:       pa = pe ^ 4'b0001;
         2: begin
            if (pi == 7'h5A)      pa = pe ^ 4'b1111;
            else if (pi == 7'h7F) pa = pe ^ 4'b0100;
            else                  pa = pe;
         end
         default: pa = pe;
      endcase
      pe3 = pi3[3:0] ^ {1'b0, pi3[6:4]};
      pa3 = (pi3 == 7'h10) ? (pe3 ^ 4'b0011) : pe3;
   end

   typedef struct {
      int unsigned mc;
      int unsigned hs;
      int unsigned mh;
      int unsigned fv;
      int unsigned fvld;
      int unsigned lat;
      int unsigned tstart;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   exp_t m1, m3;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a done pulse appears
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q1.size() == 0) chk("dut1_unexpected_done", done, 0);
         else begin
            m1 = q1.pop_front();
            chk("dut1_latency", cyc - m1.tstart, m1.lat);
            chk("dut1_mismatch_cnt", mc, m1.mc);
            chk("dut1_hd_sum", hs, m1.hs);
            chk("dut1_max_hd", mh, m1.mh);
            chk("dut1_first_err_vec", fv, m1.fv);
            chk("dut1_first_err_valid", fvld, m1.fvld);
            chk("dut1_results_valid", rv, 1);
            chk("dut1_busy_at_done", busy, 0);
         end
      end
      if (done3 === 1'b1) begin
         if (q3.size() == 0) chk("dut3_unexpected_done", done3, 0);
         else begin
            m3 = q3.pop_front();
            chk("dut3_latency", cyc - m3.tstart, m3.lat);
            chk("dut3_mismatch_cnt", mc3, m3.mc);
            chk("dut3_hd_sum", hs3, m3.hs);
            chk("dut3_max_hd", mh3, m3.mh);
            chk("dut3_first_err_vec", fv3, m3.fv);
            chk("dut3_first_err_valid", fvld3, m3.fvld);
            chk("dut3_results_valid", rv3, 1);
            chk("dut3_busy_at_done", busy3, 0);
         end
      end
   end

   function automatic exp_t mk(input int unsigned a, b, c, d, e, lat);
      exp_t r;
      r.mc = a; r.hs = b; r.mh = c; r.fv = d; r.fvld = e; r.lat = lat; r.tstart = 0;
      return r;
   endfunction

   task automatic kick1(input int m, input bit push, input exp_t e);
      @(negedge clk);
      mode = m;
      e.tstart = cyc + 1;
      if (push) q1.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic kick3(input exp_t e);
      @(negedge clk);
      e.tstart = cyc + 1;
      q3.push_back(e);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
   endtask

   task automatic drain(input int which);
      for (int i = 0; i < 1500; i++) begin
         if ((which == 1 && q1.size() == 0) || (which == 3 && q3.size() == 0)) break;
         @(negedge clk);
      end
      if (which == 1 && q1.size() != 0) begin
         chk("dut1_done_timeout", q1.size(), 0);
         q1.delete();
      end
      if (which == 3 && q3.size() != 0) begin
         chk("dut3_done_timeout", q3.size(), 0);
         q3.delete();
      end
   endtask

   task automatic check_zero(input string name);
      chk({name, "_dut1"}, {pi, busy, done, rv, mc, hs, mh, fv, fvld}, 0);
      chk({name, "_dut3"}, {pi3, busy3, done3, rv3, mc3, hs3, mh3, fv3, fvld3}, 0);
   endtask

   int unsigned t0;

   initial begin
      start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
      #1 check_zero("reset_state");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Exact match everywhere
      kick1(0, 1'b1, mk(0, 0, 0, 0, 0, 256));
      drain(1);
      @(negedge clk);
      chk("hold_results_valid", rv, 1);
      chk("idle_busy", busy, 0);

      // Bit 0 always inverted; also probe pi cadence
      kick1(1, 1'b1, mk(128, 128, 1, 0, 1, 256));
      t0 = cyc;
      repeat (20) @(negedge clk);
      chk("dut1_pi_at_t20", pi, 10);
      chk("dut1_busy_mid", busy, 1);
      drain(1);

      // Two isolated errors, plus an ignored start while busy
      kick1(2, 1'b1, mk(2, 5, 4, 7'h5A, 1, 256));
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_ignored_start", busy, 1);
      drain(1);

      // Abort sampled on the 50th edge of the sweep
      kick1(1, 1'b0, mk(0, 0, 0, 0, 0, 0));
      repeat (49) @(negedge clk);
      chk("pre_abort_pi", pi, 24);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_results_valid", rv, 0);
      chk("abort_pi_hold", pi, 24);
      repeat (300) @(negedge clk);
      chk("abort_results_valid_later", rv, 0);
      kick1(1, 1'b1, mk(128, 128, 1, 0, 1, 256));
      drain(1);

      // Asynchronous reset mid-sweep
      kick1(1, 1'b0, mk(0, 0, 0, 0, 0, 0));
      repeat (40) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 check_zero("mid_sweep_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_reset_busy", busy, 0);

      // SETTLE=3 instance
      kick3(mk(1, 2, 2, 7'h10, 1, 512));
      t0 = cyc;
      repeat (40) @(negedge clk);
      chk("dut3_pi_at_t40", pi3, 10);
      repeat (3) @(negedge clk);
      chk("dut3_pi_at_t43", pi3, 10);
      @(negedge clk);
      chk("dut3_pi_at_t44", pi3, 11);
      drain(3);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
